// File: rtl/mac_pkg.sv
// Shared types for the sum-of-squares MAC result path.
package mac_pkg;

    localparam int unsigned ACC_W = 20;

    typedef logic [ACC_W-1:0] acc_t;

    typedef struct packed {
        logic wrap;
        acc_t value;
    } mac_result_t;

endpackage

// File: rtl/sink_fifo.sv
// Result FIFO: storage, rd/wr pointers, explicit occupancy count and push/pop arbitration.
module sink_fifo
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  mac_result_t                wr_data,
    input  logic                       pop_req,
    output mac_result_t                rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       push_drop_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    mac_result_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               empty_c;
    logic               full_c;
    logic               pop_c;
    logic               wr_en_c;
    logic [CNT_W-1:0]   count_nxt_c;

    assign empty_c = (count == '0);
    assign full_c  = (count == CNT_W'(DEPTH));

    // A pop frees the slot a same-edge push into a full FIFO needs.
    assign pop_c       = !empty_c && pop_req;
    assign wr_en_c     = push && (!full_c || pop_c);
    assign push_drop_c = push && full_c && !pop_c;

    always_comb begin
        count_nxt_c = count;
        case ({wr_en_c, pop_c})
            2'b10:   count_nxt_c = count + CNT_W'(1);
            2'b01:   count_nxt_c = count - CNT_W'(1);
            default: count_nxt_c = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt_c;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes a slot.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_valid = !empty_c;
    assign rd_data  = empty_c ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mac_result_sink.sv
// Consumer of MAC results: wrap detection, sticky overflow/drop flags, FIFO to a valid/ready reader.
module mac_result_sink
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = ACC_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          f,
    input  logic                       valid_out,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_wrap,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       drop,
    input  logic                       clear_flags
);

    acc_t        prev_f;
    logic        wrap_c;
    logic        drop_evt_c;
    mac_result_t wr_entry_c;
    mac_result_t head_c;

    // Unsigned compare against the last sampled word, dropped or not.
    assign wrap_c     = valid_out && (acc_t'(f) < prev_f);
    assign wr_entry_c = '{wrap: wrap_c, value: acc_t'(f)};

    sink_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (valid_out),
        .wr_data     (wr_entry_c),
        .pop_req     (m_ready),
        .rd_data     (head_c),
        .rd_valid    (m_valid),
        .count       (count),
        .push_drop_c (drop_evt_c)
    );

    assign m_data = DATA_W'(head_c.value);
    assign m_wrap = head_c.wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_f <= '0;
        end else if (valid_out) begin
            prev_f <= acc_t'(f);
        end
    end

    // Set events take priority over a same-edge clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop     <= 1'b0;
        end else begin
            if (wrap_c) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (drop_evt_c) begin
                drop <= 1'b1;
            end else if (clear_flags) begin
                drop <= 1'b0;
            end
        end
    end

endmodule
